// File: rtl/ft232h_device.sv
// Chip-side model of the FT232H 245 synchronous FIFO bus: host valid/ready streams
// on one side, rxf_n/txe_n/oe_n/rd_n/wr_n/adbus on the other, with sticky misuse flags.
module ft232h_device #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_tx_valid,
  output logic       h_tx_ready,
  input  logic [7:0] h_tx_data,
  output logic       h_rx_valid,
  input  logic       h_rx_ready,
  output logic [7:0] h_rx_data,
  output logic       rxf_n,
  input  logic       oe_n,
  input  logic       rd_n,
  output logic       txe_n,
  input  logic       wr_n,
  inout  wire  [7:0] adbus,
  output logic       err_conflict,
  output logic       err_overrun,
  output logic       err_underrun
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = 1;
  localparam logic [AW-1:0]  PTR_ONE  = 1;

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] rx_rd, rx_wr, tx_rd, tx_wr;
  logic [AW:0]   rx_count, tx_count;
  logic [AW:0]   rx_count_next, tx_count_next;
  logic          rx_push, rx_pop, tx_push, tx_pop;

  assign h_tx_ready = (rx_count != CNT_FULL);
  assign h_rx_valid = (tx_count != '0);
  assign h_rx_data  = tx_mem[tx_rd];
  assign adbus      = oe_n ? 8'bz : rx_mem[rx_rd];

  // Bus-side strobes qualify on the registered flags, exactly as the real chip does.
  assign rx_push = h_tx_valid && h_tx_ready;
  assign rx_pop  = !rd_n && !rxf_n;
  assign tx_push = !wr_n && !txe_n;
  assign tx_pop  = h_rx_valid && h_rx_ready;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rx_count_next = rx_count;
    if (rx_push && !rx_pop)      rx_count_next = rx_count + CNT_ONE;
    else if (!rx_push && rx_pop) rx_count_next = rx_count - CNT_ONE;

    tx_count_next = tx_count;
    if (tx_push && !tx_pop)      tx_count_next = tx_count + CNT_ONE;
    else if (!tx_push && tx_pop) tx_count_next = tx_count - CNT_ONE;
  end

  // NOTE: buffer storage has no reset; pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= h_tx_data;
    if (tx_push) tx_mem[tx_wr] <= adbus;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rd        <= '0;
      rx_wr        <= '0;
      tx_rd        <= '0;
      tx_wr        <= '0;
      rx_count     <= '0;
      tx_count     <= '0;
      rxf_n        <= 1'b1;
      txe_n        <= 1'b1;
      err_conflict <= 1'b0;
      err_overrun  <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
      rx_count <= rx_count_next;
      tx_count <= tx_count_next;
      rxf_n    <= (rx_count_next == '0);
      txe_n    <= (tx_count_next == CNT_FULL);
      // Misuse flags are sticky until reset.
      if (!oe_n && !wr_n) err_conflict <= 1'b1;
      if (!wr_n && txe_n) err_overrun  <= 1'b1;
      if (!rd_n && rxf_n) err_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ft232h_device.sv
// Directed bench for ft232h_device: a per-cycle vector table for the basic paths,
// then hand-written sequences for fill/overrun, wrap-around, full duplex, misuse and reset.
module tb_ft232h_device;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_tx_valid;
  logic       h_tx_ready;
  logic [7:0] h_tx_data;
  logic       h_rx_valid;
  logic       h_rx_ready;
  logic [7:0] h_rx_data;
  logic       rxf_n;
  logic       oe_n;
  logic       rd_n;
  logic       txe_n;
  logic       wr_n;
  wire  [7:0] adbus;
  logic       err_conflict;
  logic       err_overrun;
  logic       err_underrun;
  logic       tb_drv;
  logic [7:0] tb_byte;

  int checks = 0;
  int errors = 0;

  assign adbus = tb_drv ? tb_byte : 8'bz;

  always #5 clk = ~clk;

  ft232h_device #(.DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .h_tx_valid   (h_tx_valid),
    .h_tx_ready   (h_tx_ready),
    .h_tx_data    (h_tx_data),
    .h_rx_valid   (h_rx_valid),
    .h_rx_ready   (h_rx_ready),
    .h_rx_data    (h_rx_data),
    .rxf_n        (rxf_n),
    .oe_n         (oe_n),
    .rd_n         (rd_n),
    .txe_n        (txe_n),
    .wr_n         (wr_n),
    .adbus        (adbus),
    .err_conflict (err_conflict),
    .err_overrun  (err_overrun),
    .err_underrun (err_underrun)
  );

  typedef struct {
    logic       htv;
    logic [7:0] htd;
    logic       oe;
    logic       rd;
    logic       wr;
    logic [7:0] wd;
    logic       hrr;
    logic       chk_bus;
    logic [7:0] bus;
    logic       rxf;
    logic       txe;
    logic       hrv;
    logic [7:0] hrd;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h_tx_valid = 1'b0;
    h_tx_data  = 8'h00;
    h_rx_ready = 1'b0;
    oe_n       = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    tb_drv     = 1'b0;
    tb_byte    = 8'h00;
  endtask

  task automatic bus_write(input logic [7:0] b);
    wr_n    = 1'b0;
    tb_drv  = 1'b1;
    tb_byte = b;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_no_errors(input string tag);
    check({tag, " err_conflict"}, {7'd0, err_conflict}, 8'd0);
    check({tag, " err_overrun"},  {7'd0, err_overrun},  8'd0);
    check({tag, " err_underrun"}, {7'd0, err_underrun}, 8'd0);
  endtask

  vec_t   vecs [12];
  logic [7:0] q [$];
  int     sent, rcvd;
  logic   push, pop;

  initial begin
    vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h66};
    vecs[10] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00};

    idle();
    rst = 1'b1;
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("reset rxf_n",      {7'd0, rxf_n},      8'd1);
    check("reset txe_n",      {7'd0, txe_n},      8'd1);
    check("reset h_rx_valid", {7'd0, h_rx_valid}, 8'd0);
    check("reset h_tx_ready", {7'd0, h_tx_ready}, 8'd1);
    check_no_errors("reset");

    // Vector table: burst host->FPGA, FPGA->host, mixed traffic.
    for (int i = 0; i < 12; i++) begin
      h_tx_valid = vecs[i].htv;
      h_tx_data  = vecs[i].htd;
      oe_n       = vecs[i].oe;
      rd_n       = vecs[i].rd;
      wr_n       = vecs[i].wr;
      tb_drv     = !vecs[i].wr;
      tb_byte    = vecs[i].wd;
      h_rx_ready = vecs[i].hrr;
      #1;
      if (vecs[i].chk_bus) check($sformatf("vec%0d adbus", i), adbus, vecs[i].bus);
      tick();
      check($sformatf("vec%0d rxf_n", i),      {7'd0, rxf_n},      {7'd0, vecs[i].rxf});
      check($sformatf("vec%0d txe_n", i),      {7'd0, txe_n},      {7'd0, vecs[i].txe});
      check($sformatf("vec%0d h_rx_valid", i), {7'd0, h_rx_valid}, {7'd0, vecs[i].hrv});
      if (vecs[i].hrv) check($sformatf("vec%0d h_rx_data", i), h_rx_data, vecs[i].hrd);
    end
    idle();
    check_no_errors("table");

    // TX fill to DEPTH, overrun on the 17th write, then ordered drain.
    do_reset();
    tick();
    for (int i = 0; i < 16; i++) begin
      bus_write(8'(i));
      tick();
      check($sformatf("fill%0d txe_n", i), {7'd0, txe_n}, (i == 15) ? 8'd1 : 8'd0);
    end
    bus_write(8'hAA);
    tick();
    check("overrun err_overrun", {7'd0, err_overrun}, 8'd1);
    check("overrun txe_n",       {7'd0, txe_n},       8'd1);
    idle();
    h_rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("drain%0d h_rx_valid", i), {7'd0, h_rx_valid}, 8'd1);
      check($sformatf("drain%0d h_rx_data", i),  h_rx_data,          8'(i));
      tick();
      if (i == 0) check("drain txe_n reopens", {7'd0, txe_n}, 8'd0);
    end
    check("drain empty h_rx_valid", {7'd0, h_rx_valid}, 8'd0);
    idle();

    // Wrap-around: 40 interleaved pushes/pops, occupancy 0..3.
    do_reset();
    q.delete();
    sent = 0;
    rcvd = 0;
    for (int t = 0; t < 200 && rcvd < 40; t++) begin
      push = (sent < 40) && (q.size() < 3) && ((t % 4) != 3);
      pop  = (q.size() > 0) && (((t % 3) != 0) || (sent == 40));
      h_tx_valid = push;
      h_tx_data  = 8'(sent);
      oe_n       = !pop;
      rd_n       = !pop;
      #1;
      if (pop) check($sformatf("wrap pop%0d adbus", rcvd), adbus, q[0]);
      tick();
      if (pop) begin
        void'(q.pop_front());
        rcvd++;
      end
      if (push) begin
        q.push_back(8'(sent));
        sent++;
      end
    end
    idle();
    check("wrap received count", 8'(rcvd), 8'd40);
    check("wrap final rxf_n", {7'd0, rxf_n}, 8'd1);
    check_no_errors("wrap");

    // Full duplex: preload 2 in each buffer, then push+pop both sides for 6 cycles.
    do_reset();
    h_tx_valid = 1'b1;
    h_tx_data  = 8'hB0;
    tick();
    h_tx_data  = 8'hB1;
    bus_write(8'hC0);
    tick();
    h_tx_valid = 1'b0;
    bus_write(8'hC1);
    tick();
    for (int i = 0; i < 6; i++) begin
      h_tx_valid = 1'b1;
      h_tx_data  = 8'hB2 + 8'(i);
      rd_n       = 1'b0;
      bus_write(8'hC2 + 8'(i));
      h_rx_ready = 1'b1;
      #1;
      check($sformatf("duplex%0d h_rx_data", i), h_rx_data, 8'hC0 + 8'(i));
      tick();
      check($sformatf("duplex%0d rxf_n", i), {7'd0, rxf_n}, 8'd0);
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      oe_n = 1'b0;
      rd_n = 1'b0;
      h_rx_ready = 1'b1;
      #1;
      check($sformatf("duplex rx tail%0d", i), adbus, 8'hB6 + 8'(i));
      check($sformatf("duplex tx tail%0d", i), h_rx_data, 8'hC6 + 8'(i));
      tick();
    end
    idle();
    check("duplex rx drained rxf_n",   {7'd0, rxf_n},      8'd1);
    check("duplex tx drained h_rx_valid", {7'd0, h_rx_valid}, 8'd0);
    check_no_errors("duplex");

    // Misuse: conflict (write still accepted) and underrun (no pointer movement).
    do_reset();
    tick();
    oe_n = 1'b0;
    wr_n = 1'b0;
    tick();
    idle();
    check("conflict err_conflict", {7'd0, err_conflict}, 8'd1);
    check("conflict write kept",   {7'd0, h_rx_valid},   8'd1);
    rd_n = 1'b0;
    tick();
    idle();
    check("underrun err_underrun", {7'd0, err_underrun}, 8'd1);
    h_tx_valid = 1'b1;
    h_tx_data  = 8'h99;
    tick();
    idle();
    oe_n = 1'b0;
    rd_n = 1'b0;
    #1;
    check("underrun no ptr move adbus", adbus, 8'h99);
    tick();
    idle();
    check("underrun single pop rxf_n", {7'd0, rxf_n}, 8'd1);

    // Reset mid-operation with 5 bytes in each buffer.
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      h_tx_valid = 1'b1;
      h_tx_data  = 8'h60 + 8'(i);
      bus_write(8'h70 + 8'(i));
      tick();
    end
    idle();
    rd_n = 1'b0;
    oe_n = 1'b0;
    wr_n = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("midrst rxf_n",        {7'd0, rxf_n},        8'd1);
    check("midrst h_rx_valid",   {7'd0, h_rx_valid},   8'd0);
    check("midrst h_tx_ready",   {7'd0, h_tx_ready},   8'd1);
    check("midrst txe_n first",  {7'd0, txe_n},        8'd1);
    check_no_errors("midrst");
    tick();
    check("midrst txe_n reopens", {7'd0, txe_n}, 8'd0);
    check("midrst still empty",   {7'd0, rxf_n}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft232h_device.md
# ft232h_device

Synthesizable model of the FT232H chip side of the 245 synchronous FIFO bus, used in simulation and FPGA loopback builds to stand in for the USB chip opposite the FPGA-side bridge. It presents host-side valid/ready streams: bytes pushed by the host queue in an RX buffer and are offered on `adbus` via `rxf_n`/`oe_n`/`rd_n`. Bytes written by the FPGA via `txe_n`/`wr_n` queue in a TX buffer drained by the host stream. Protocol misuse is flagged with sticky error bits.

## Interface
- `DEPTH`, 16, entries per buffer; power of two, ≥2.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `h_tx_valid` in 1: host has a byte for the FPGA.
- `h_tx_ready` out 1: RX buffer accepts a byte.
- `h_tx_data` in 8: host byte.
- `h_rx_valid` out 1: TX buffer holds a byte for the host.
- `h_rx_ready` in 1: host takes the head byte.
- `h_rx_data` out 8: TX buffer head.
- `rxf_n` out 1: low when the RX buffer is non-empty.
- `oe_n` in 1: FPGA output-enable request, active low.
- `rd_n` in 1: FPGA read strobe, active low.
- `txe_n` out 1: low when the TX buffer has space.
- `wr_n` in 1: FPGA write strobe, active low.
- `adbus` inout 8: shared data bus.
- `err_conflict` out 1: sticky; `oe_n` and `wr_n` were both low on an edge.
- `err_overrun` out 1: sticky; `wr_n` low while `txe_n` high.
- `err_underrun` out 1: sticky; `rd_n` low while `rxf_n` high.

## Operation
- Two independent circular buffers, RX and TX. Each has `DEPTH` entries, read/write pointers of log2(DEPTH) bits that wrap naturally, and a count of log2(DEPTH)+1 bits.
- Host push: `h_tx_ready = (rx_count != DEPTH)`. The byte is written on an edge with `h_tx_valid && h_tx_ready`. Readiness depends on count only; a same-cycle bus pop does not make a full buffer ready.
- Bus drive: `adbus` = RX head byte while `oe_n == 0`, otherwise `8'bz`. With RX empty and `oe_n` low, the model drives the stale head entry.
- Bus pop: on an edge with `rd_n == 0 && rxf_n == 0`, advance the RX read pointer. Consecutive low `rd_n` cycles pop one byte per cycle.
- Bus push: on an edge with `wr_n == 0 && txe_n == 0`, write `adbus` into TX. With `wr_n` low and `txe_n` high, the byte is dropped and `err_overrun` is set.
- Host pop: `h_rx_valid = (tx_count != 0)` and `h_rx_data` = TX head. Advance on `h_rx_valid && h_rx_ready`.
- Simultaneous push and pop on the same buffer: the count is unchanged and both pointers advance.
- Flags are registered from next-state counts: `rxf_n <= (rx_count_next == 0)` and `txe_n <= (tx_count_next == DEPTH)`.
- Errors: `err_conflict` is set on any edge with `oe_n == 0 && wr_n == 0`; the write is still accepted if `txe_n` is low. `err_underrun` is set on `rd_n == 0 && rxf_n == 1`, with no pop. Error bits clear only on `rst`.
- Reset (`rst` high at an edge): pointers and counts go to 0, `rxf_n=1`, `txe_n=1`, all `err_*` go to 0, `h_tx_ready=1`, `h_rx_valid=0`, and `adbus` follows `oe_n`. Buffer contents are not cleared. Reset mid-transfer discards all queued bytes.

## Timing
- `h_tx_ready`, `h_rx_valid`, `h_rx_data` and `adbus` are combinational from state and `oe_n`. `rxf_n` and `txe_n` are registered.
- Host push at edge N gives `rxf_n` low after edge N. The byte is visible on `adbus` in the same cycle that `oe_n` is low.
- Last byte popped at edge N gives `rxf_n` high after edge N.
- Bus write filling TX at edge N gives `txe_n` high after edge N. A host pop at edge M gives `txe_n` low after M.
- `txe_n` reads 1 in the first cycle after reset release and 0 from the next edge on.
- Throughput: one byte per clock per direction, in both directions concurrently.

## Test plan
- **Host to FPGA burst.** Push 0x11, 0x22, 0x33. Then hold `oe_n`=0 and `rd_n`=0 for 3 cycles. Required: `adbus` shows 0x11, 0x22, 0x33 on successive cycles, and `rxf_n` goes high after the third edge.
- **FPGA to host fill.** With `DEPTH`=16 and `h_rx_ready`=0, write 0x00..0x0F with `wr_n`=0. Required: `txe_n`=1 after the 16th edge. A 17th write (0xAA) sets `err_overrun` and is not stored. Draining then yields exactly 0x00..0x0F in order.
- **Wrap-around.** Do 40 interleaved host pushes and bus pops of an incrementing byte, with occupancy between 0 and 3. Required: in-order data and no error bits set.
- **Simultaneous full-duplex traffic.** Push to RX while reading from RX, and write to TX while the host pops TX, all in the same cycles. Required: counts stay constant and data order is preserved in both buffers.
- **Misuse.** Drive `oe_n`=0 and `wr_n`=0 together: `err_conflict`=1. Drive `rd_n`=0 with RX empty: `err_underrun`=1 and no pointer movement.
- **Reset mid-operation.** With 5 bytes queued in each buffer, pulse `rst` for 1 cycle. Required: `rxf_n`=1, `h_rx_valid`=0, all `err_*`=0, and `txe_n` returns to 0 one edge after release.
